vga_render: RTL and testbench

//  Downstream display stage of the Breakout game: consumes the game-logic outputs (ball x/y, paddle

---
 rtl/vga_pkg.sv | 88 ++++++++
 rtl/vga_render_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 55 +++++
 rtl/vga_render.sv | 158 +++++++++++++++
 tb/tb_vga_render.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing, geometry and colour constants for the Breakout VGA display stage.
package vga_pkg;

    // 800x600@72Hz timing, 50 MHz pixel clock
    localparam int H_VIS   = 800;
    localparam int H_FP    = 56;
    localparam int H_SYNC  = 120;
    localparam int H_BP    = 64;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 1040

    localparam int V_VIS   = 600;
    localparam int V_FP    = 37;
    localparam int V_SYNC  = 6;
    localparam int V_BP    = 23;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 666

    localparam logic SYNC_POL = 1'b1;

    localparam int COLOR_W = 4;
    localparam int RGB_W   = 3 * COLOR_W;

    localparam int H_W = 11;    // holds 0..1039
    localparam int V_W = 10;    // holds 0..665

    // Brick row: brick0 is 70 wide, bricks 1..11 are 60 wide, brick12 fills to the right edge
    localparam int N_BRICK  = 13;
    localparam int BRICK_Y0 = 25;
    localparam int BRICK_Y1 = 54;
    localparam int BRICK0_W = 70;
    localparam int BRICK_W  = 60;

    // Paddle: 200 wide, centre 60 columns drawn yellow
    localparam int PAD_Y0     = 575;
    localparam int PAD_Y1     = 589;
    localparam int PAD_STEP   = 50;
    localparam int PAD_LEN    = 200;
    localparam int PAD_MAX    = 12;
    localparam int PAD_MID_LO = 70;
    localparam int PAD_MID_HI = 129;

    localparam int BALL_SIZE = 30;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t C_RED     = 12'hF00;
    localparam rgb_t C_GREEN   = 12'h0F0;
    localparam rgb_t C_YELLOW  = 12'hFF0;
    localparam rgb_t C_WHITE   = 12'hFFF;
    localparam rgb_t C_BLACK   = 12'h000;
    localparam rgb_t C_WINBLUE = 12'h008;

    typedef struct packed {
        logic [9:0]         ball_x;
        logic [9:0]         ball_y;
        logic [3:0]         paddle_pos;
        logic [N_BRICK-1:0] brick;
        logic               go;
        logic               finish;
    } game_state_t;

    localparam game_state_t SNAP_RESET = '{
        ball_x:     10'd0,
        ball_y:     10'd0,
        paddle_pos: 4'd0,
        brick:      {N_BRICK{1'b1}},
        go:         1'b0,
        finish:     1'b0
    };

    typedef struct packed {
        logic ball;
        logic paddle;
        logic pad_mid;
        logic brick;
        logic win;
    } hits_t;

    // Rightmost column owned by brick k
    function automatic logic [H_W-1:0] brick_hi(input int k);
        if (k == 0)
            return H_W'(BRICK0_W - 1);
        else if (k == N_BRICK - 1)
            return H_W'(H_VIS - 1);
        else
            return H_W'(BRICK0_W + BRICK_W * k - 1);
    endfunction

endpackage

// File: rtl/vga_render_if.sv
// Game-state inputs and VGA outputs of the display stage, bundled as one bus.
interface vga_render_if;
    import vga_pkg::*;

    logic [9:0]         ball_x;
    logic [9:0]         ball_y;
    logic [3:0]         paddle_pos;
    logic [N_BRICK-1:0] brick;
    logic               go;
    logic               finish;

    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               frame_tick;

    // Game logic side: supplies state, observes the display
    modport master (
        output ball_x, ball_y, paddle_pos, brick, go, finish,
        input  hsync, vsync, red, green, blue, frame_tick
    );

    // Renderer side
    modport slave (
        input  ball_x, ball_y, paddle_pos, brick, go, finish,
        output hsync, vsync, red, green, blue, frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters, raw sync levels, visible-area flag and the per-frame tick.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] h_cnt_o,
    output logic [V_W-1:0] v_cnt_o,
    output logic           in_vis_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           frame_tick_o
);

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           tick_q, tick_d;

    // Next raster position; the tick is decoded from it so it can be registered
    always_comb begin
        h_d = h_q + H_W'(1);
        v_d = v_q;
        if (h_q == H_W'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == V_W'(V_TOTAL - 1))
                v_d = '0;
            else
                v_d = v_q + V_W'(1);
        end
        tick_d = (h_d == '0) && (v_d == V_W'(V_VIS));
    end

    // Counter and tick registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            tick_q <= tick_d;
        end
    end

    assign h_cnt_o      = h_q;
    assign v_cnt_o      = v_q;
    assign in_vis_o     = (h_q < H_W'(H_VIS)) && (v_q < V_W'(V_VIS));
    assign hsync_o      = (h_q >= H_W'(H_VIS + H_FP) && h_q <= H_W'(H_VIS + H_FP + H_SYNC - 1))
                          ? SYNC_POL : ~SYNC_POL;
    assign vsync_o      = (v_q >= V_W'(V_VIS + V_FP) && v_q <= V_W'(V_VIS + V_FP + V_SYNC - 1))
                          ? SYNC_POL : ~SYNC_POL;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/vga_render.sv
// Breakout display stage: per-frame snapshot of game state, region hit compare, colour mux.
module vga_render
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    vga_render_if.slave bus
);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           in_vis;
    logic           hs_raw;
    logic           vs_raw;
    logic           frame_tick;

    vga_timing_gen u_timing (
        .clk          (clk),
        .rst          (rst),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .in_vis_o     (in_vis),
        .hsync_o      (hs_raw),
        .vsync_o      (vs_raw),
        .frame_tick_o (frame_tick)
    );

    function automatic logic [3:0] clamp_paddle(input logic [3:0] p);
        return (p > 4'(PAD_MAX)) ? 4'(PAD_MAX) : p;
    endfunction

    function automatic rgb_t pick_colour(input logic vld, input hits_t h);
        if (!vld)
            return C_BLACK;
        else if (h.ball)
            return C_WHITE;
        else if (h.paddle)
            return h.pad_mid ? C_YELLOW : C_GREEN;
        else if (h.brick)
            return C_RED;
        else
            return h.win ? C_WINBLUE : C_BLACK;
    endfunction

    game_state_t snap_q, snap_d;

    // Capture all game inputs together at the start of vertical blanking
    always_comb begin
        snap_d = snap_q;
        if (frame_tick) begin
            snap_d.ball_x     = bus.ball_x;
            snap_d.ball_y     = bus.ball_y;
            snap_d.paddle_pos = clamp_paddle(bus.paddle_pos);
            snap_d.brick      = bus.brick;
            snap_d.go         = bus.go;
            snap_d.finish     = bus.finish;
        end
    end

    // Snapshot register, held for the whole following visible frame
    always_ff @(posedge clk) begin
        if (rst)
            snap_q <= SNAP_RESET;
        else
            snap_q <= snap_d;
    end

    // go is latched with the rest of the state but does not affect drawing
    logic unused_go;
    assign unused_go = snap_q.go;

    // Ball compare is signed and one bit wider than the counter so that a ball near
    // the top/left edge clips instead of wrapping around
    logic signed [11:0] hx, vy, bx_lo, bx_hi, by_lo, by_hi;
    logic [H_W-1:0]     pad_left, pad_off;
    logic               brick_found;
    hits_t              hits_d;

    // S1 hit decode from the current raster position
    always_comb begin
        hx    = $signed({1'b0, h_cnt});
        vy    = $signed({2'b00, v_cnt});
        bx_hi = $signed({2'b00, snap_q.ball_x}) - 12'sd1;
        bx_lo = $signed({2'b00, snap_q.ball_x}) - $signed(12'(BALL_SIZE));
        by_hi = $signed({2'b00, snap_q.ball_y}) - 12'sd1;
        by_lo = $signed({2'b00, snap_q.ball_y}) - $signed(12'(BALL_SIZE));

        hits_d.ball = (hx >= bx_lo) && (hx <= bx_hi) && (vy >= by_lo) && (vy <= by_hi);

        pad_left = H_W'(snap_q.paddle_pos) * H_W'(PAD_STEP);
        pad_off  = h_cnt - pad_left;
        hits_d.paddle  = (v_cnt >= V_W'(PAD_Y0)) && (v_cnt <= V_W'(PAD_Y1)) &&
                         (h_cnt >= pad_left) && (pad_off <= H_W'(PAD_LEN - 1)) &&
                         (h_cnt < H_W'(H_VIS));
        hits_d.pad_mid = (pad_off >= H_W'(PAD_MID_LO)) && (pad_off <= H_W'(PAD_MID_HI));

        // Bricks tile columns 0..799 left to right, so the first brick whose right
        // edge is at or beyond h owns the pixel; a shared edge goes to the lower index
        hits_d.brick = 1'b0;
        brick_found  = 1'b0;
        if ((v_cnt >= V_W'(BRICK_Y0)) && (v_cnt <= V_W'(BRICK_Y1))) begin
            for (int k = 0; k < N_BRICK; k++) begin
                if (!brick_found && (h_cnt <= brick_hi(k))) begin
                    brick_found  = 1'b1;
                    hits_d.brick = snap_q.brick[4'(k)];
                end
            end
        end

        hits_d.win = snap_q.finish;
    end

    logic  vld_p1_q;
    hits_t hits_p1_q;
    logic  hs_p1_q, vs_p1_q;

    // ---- S1 boundary: region hits registered, valid = visible area ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            hs_p1_q  <= ~SYNC_POL;
            vs_p1_q  <= ~SYNC_POL;
        end else begin
            vld_p1_q <= in_vis;
            hs_p1_q  <= hs_raw;
            vs_p1_q  <= vs_raw;
        end
    end

    // S1 hit data carries no reset; the valid bit masks it
    always_ff @(posedge clk) begin
        hits_p1_q <= hits_d;
    end

    rgb_t rgb_p2_q;
    logic hs_p2_q, vs_p2_q;

    // ---- S2 boundary: colour mux result and syncs aligned with it ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p2_q <= C_BLACK;
            hs_p2_q  <= ~SYNC_POL;
            vs_p2_q  <= ~SYNC_POL;
        end else begin
            rgb_p2_q <= pick_colour(vld_p1_q, hits_p1_q);
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
        end
    end

    assign bus.red        = rgb_p2_q[RGB_W-1 -: COLOR_W];
    assign bus.green      = rgb_p2_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue       = rgb_p2_q[COLOR_W-1:0];
    assign bus.hsync      = hs_p2_q;
    assign bus.vsync      = vs_p2_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_render.sv
// Directed bench for vga_render: sync timing, snapshot behaviour, geometry, priority, reset.
module tb_vga_render;

    localparam int H_TOT = 1040;
    localparam int FRAME = 1040 * 666;

    localparam logic [11:0] K_RED    = 12'hF00;
    localparam logic [11:0] K_GREEN  = 12'h0F0;
    localparam logic [11:0] K_YELLOW = 12'hFF0;
    localparam logic [11:0] K_WHITE  = 12'hFFF;
    localparam logic [11:0] K_BLACK  = 12'h000;
    localparam logic [11:0] K_BLUE   = 12'h008;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] c;
        string       name;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   t_tick1 = 0;

    vga_render_if vif();

    vga_render dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    // Raster position model: cycles since the last reset edge
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [11:0] rgb;
    assign rgb = {vif.red, vif.green, vif.blue};

    // Output cycle at which pixel (x,y) appears, two cycles after its counter value
    function automatic int pix(input int x, input int y);
        return (y * H_TOT + x + 2) % FRAME;
    endfunction

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((cyc % FRAME) != target) && (n < FRAME + 8));
        if ((cyc % FRAME) != target) begin
            tests++;
            fails++;
            $display("FAIL wait_pos: timed out at cyc %0d, wanted position %0d", cyc, target);
        end
    endtask

    task automatic drive(input int bx, input int by, input int pp, input logic [12:0] br, input logic fin);
        vif.ball_x     = 10'(bx);
        vif.ball_y     = 10'(by);
        vif.paddle_pos = 4'(pp);
        vif.brick      = br;
        vif.go         = 1'b1;
        vif.finish     = fin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        tests++; if (vif.hsync !== 1'b0) begin fails++; $display("FAIL reset_hsync: got %b want 0", vif.hsync); end
        tests++; if (vif.vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync: got %b want 0", vif.vsync); end
        tests++; if (rgb !== K_BLACK) begin fails++; $display("FAIL reset_rgb: got %h want %h", rgb, K_BLACK); end
        tests++; if (vif.frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", vif.frame_tick); end
        rst = 1'b0;
    endtask

    task automatic test_hsync();
        int n, t_rise, t_fall, t_rise2;
        n = 0;
        while (vif.hsync !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        t_rise = cyc;
        tests++; if (t_rise != 858) begin fails++; $display("FAIL hsync_rise: at cyc %0d want 858", t_rise); end
        n = 0;
        while (vif.hsync !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        t_fall = cyc;
        tests++; if (t_fall - t_rise != 120) begin fails++; $display("FAIL hsync_width: got %0d want 120", t_fall - t_rise); end
        n = 0;
        while (vif.hsync !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        t_rise2 = cyc;
        tests++; if (t_rise2 - t_rise != 1040) begin fails++; $display("FAIL hsync_period: got %0d want 1040", t_rise2 - t_rise); end
    endtask

    // First frame draws from the reset snapshot: all bricks, paddle at column 0
    task automatic test_reset_snapshot();
        pix_t v[$];
        v.push_back('{1039, 24, K_BLACK,  "latency_blank"});
        v.push_back('{0,    25, K_RED,    "latency_brick0"});
        v.push_back('{799,  25, K_RED,    "brick12_right"});
        v.push_back('{800,  25, K_BLACK,  "hblank_after_brick"});
        v.push_back('{10,   580, K_GREEN, "paddle0_left"});
        v.push_back('{100,  580, K_YELLOW, "paddle0_mid"});
        foreach (v[i]) begin
            wait_pos(pix(v[i].x, v[i].y));
            tests++;
            if (rgb !== v[i].c) begin
                fails++;
                $display("FAIL %s (%0d,%0d): rgb=%h expected %h", v[i].name, v[i].x, v[i].y, rgb, v[i].c);
            end
        end
        drive(400, 300, 6, 13'h1FFF, 1'b0);
    endtask

    task automatic test_frame_tick();
        int n;
        n = 0;
        while (vif.frame_tick !== 1'b1 && n < FRAME + 8) begin @(negedge clk); n++; end
        t_tick1 = cyc;
        tests++; if (cyc != 624000) begin fails++; $display("FAIL tick_position: at cyc %0d want 624000", cyc); end
        @(negedge clk);
        tests++; if (vif.frame_tick !== 1'b0) begin fails++; $display("FAIL tick_width: got %b want 0", vif.frame_tick); end
    endtask

    task automatic test_vsync();
        int n, t_rise;
        n = 0;
        while (vif.vsync !== 1'b1 && n < FRAME + 8) begin @(negedge clk); n++; end
        t_rise = cyc;
        tests++; if (t_rise != 662482) begin fails++; $display("FAIL vsync_rise: at cyc %0d want 662482", t_rise); end
        n = 0;
        while (vif.vsync !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        tests++; if (cyc - t_rise != 6240) begin fails++; $display("FAIL vsync_width: got %0d want 6240", cyc - t_rise); end
    endtask

    // Frame 2 uses state A; new inputs mid-frame must not show until the next frame
    task automatic test_no_tearing();
        pix_t v[$];
        wait_pos(pix(10, 30));
        tests++;
        if (rgb !== K_RED) begin fails++; $display("FAIL brick0_on (10,30): rgb=%h expected %h", rgb, K_RED); end
        drive(10, 300, 15, 13'h1FFE, 1'b0);
        v.push_back('{10,  40,  K_RED,    "hold_brick0"});
        v.push_back('{375, 285, K_WHITE,  "hold_ball"});
        v.push_back('{300, 580, K_GREEN,  "paddle6_left"});
        v.push_back('{400, 580, K_YELLOW, "paddle6_mid"});
        v.push_back('{700, 580, K_BLACK,  "hold_paddle_pos"});
        foreach (v[i]) begin
            wait_pos(pix(v[i].x, v[i].y));
            tests++;
            if (rgb !== v[i].c) begin
                fails++;
                $display("FAIL %s (%0d,%0d): rgb=%h expected %h", v[i].name, v[i].x, v[i].y, rgb, v[i].c);
            end
        end
    endtask

    task automatic test_frame_period();
        int n;
        n = 0;
        while (vif.frame_tick !== 1'b1 && n < FRAME + 8) begin @(negedge clk); n++; end
        tests++;
        if (cyc - t_tick1 != FRAME) begin fails++; $display("FAIL frame_period: got %0d want %0d", cyc - t_tick1, FRAME); end
    endtask

    // Frame 3: brick0 cleared, paddle_pos 15 clamps to 12, ball clipped at the left edge
    task automatic test_clamp_clip();
        pix_t v[$];
        v.push_back('{0,   25,  K_BLACK,  "brick0_off_top"});
        v.push_back('{69,  40,  K_BLACK,  "brick0_off_edge"});
        v.push_back('{70,  40,  K_RED,    "brick1_left"});
        v.push_back('{69,  54,  K_BLACK,  "brick0_off_bottom"});
        v.push_back('{0,   285, K_WHITE,  "ball_clip_left"});
        v.push_back('{9,   285, K_WHITE,  "ball_clip_right"});
        v.push_back('{10,  285, K_BLACK,  "ball_clip_past"});
        v.push_back('{599, 580, K_BLACK,  "paddle12_before"});
        v.push_back('{600, 580, K_GREEN,  "paddle12_left"});
        v.push_back('{669, 580, K_GREEN,  "paddle12_green_end"});
        v.push_back('{670, 580, K_YELLOW, "paddle12_mid_start"});
        v.push_back('{729, 580, K_YELLOW, "paddle12_mid_end"});
        v.push_back('{730, 580, K_GREEN,  "paddle12_right_zone"});
        v.push_back('{799, 580, K_GREEN,  "paddle12_right"});
        foreach (v[i]) begin
            wait_pos(pix(v[i].x, v[i].y));
            tests++;
            if (rgb !== v[i].c) begin
                fails++;
                $display("FAIL %s (%0d,%0d): rgb=%h expected %h", v[i].name, v[i].x, v[i].y, rgb, v[i].c);
            end
        end
        drive(400, 10, 6, 13'h0000, 1'b1);
    endtask

    // Frame 4: win screen background, ball clipped at the top, blanking stays black
    task automatic test_win_screen();
        pix_t v[$];
        v.push_back('{380,  0,   K_WHITE, "ball_clip_top"});
        v.push_back('{380,  9,   K_WHITE, "ball_clip_bottom"});
        v.push_back('{380,  10,  K_BLUE,  "ball_past_win"});
        v.push_back('{10,   30,  K_BLUE,  "no_brick_win"});
        v.push_back('{500,  100, K_BLUE,  "win_background"});
        v.push_back('{800,  100, K_BLACK, "win_hblank_start"});
        v.push_back('{1039, 100, K_BLACK, "win_hblank_end"});
        foreach (v[i]) begin
            wait_pos(pix(v[i].x, v[i].y));
            tests++;
            if (rgb !== v[i].c) begin
                fails++;
                $display("FAIL %s (%0d,%0d): rgb=%h expected %h", v[i].name, v[i].x, v[i].y, rgb, v[i].c);
            end
        end
    endtask

    task automatic test_mid_reset();
        wait_pos(pix(8, 300));
        tests++;
        if (rgb !== K_BLUE) begin fails++; $display("FAIL pre_reset_pixel: rgb=%h expected %h", rgb, K_BLUE); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (vif.hsync !== 1'b0) begin fails++; $display("FAIL midrst_hsync: got %b want 0", vif.hsync); end
        tests++; if (vif.vsync !== 1'b0) begin fails++; $display("FAIL midrst_vsync: got %b want 0", vif.vsync); end
        tests++; if (rgb !== K_BLACK) begin fails++; $display("FAIL midrst_rgb: got %h want %h", rgb, K_BLACK); end
        tests++; if (vif.frame_tick !== 1'b0) begin fails++; $display("FAIL midrst_tick: got %b want 0", vif.frame_tick); end
        rst = 1'b0;
        wait_pos(pix(1039, 24));
        tests++;
        if (rgb !== K_BLACK) begin fails++; $display("FAIL midrst_latency_blank: rgb=%h expected %h", rgb, K_BLACK); end
        wait_pos(pix(0, 25));
        tests++;
        if (rgb !== K_RED) begin fails++; $display("FAIL midrst_snapshot_brick: rgb=%h expected %h", rgb, K_RED); end
    endtask

    initial begin
        vif.ball_x     = '0;
        vif.ball_y     = '0;
        vif.paddle_pos = '0;
        vif.brick      = '0;
        vif.go         = 1'b0;
        vif.finish     = 1'b0;
        test_reset();
        test_hsync();
        test_reset_snapshot();
        test_frame_tick();
        test_vsync();
        test_no_tearing();
        test_frame_period();
        test_clamp_clip();
        test_win_screen();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
